// File: rtl/flash_read_ctrl.sv
// Single-word Avalon-MM flash reader feeding the playback FSM: each request
// reads the current word, and every second read steps the address with wrap.
module flash_read_ctrl #(
  parameter int                 ADDR_W   = 23,
  parameter logic [ADDR_W-1:0]  MIN_ADDR = 23'h000000,
  parameter logic [ADDR_W-1:0]  MAX_ADDR = 23'h1FFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_start,
  input  logic              back_mode,
  input  logic              restart,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [31:0]       data_out,
  output logic              read_finish,
  output logic              is_first
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_VALID, DONE} state_t;

  state_t            state, state_nxt;
  logic              restart_pend;
  logic [ADDR_W-1:0] restart_addr;
  logic [ADDR_W-1:0] step_addr;

  assign restart_addr = back_mode ? MAX_ADDR : MIN_ADDR;

  always_comb begin
    if (back_mode) step_addr = (flash_address == MIN_ADDR) ? MAX_ADDR : flash_address - 1'b1;
    else           step_addr = (flash_address == MAX_ADDR) ? MIN_ADDR : flash_address + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    flash_read  = 1'b0;
    read_finish = 1'b0;
    unique case (state)
      IDLE:       if (read_start) state_nxt = ISSUE;
      ISSUE: begin
        flash_read = 1'b1;
        if (!flash_waitrequest) state_nxt = WAIT_VALID;
      end
      WAIT_VALID: if (flash_readdatavalid) state_nxt = DONE;
      DONE: begin
        read_finish = 1'b1;
        state_nxt   = IDLE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Address and is_first hold steady across a transaction; they move only
  // in IDLE (restart) or on the DONE commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_address <= MIN_ADDR;
      is_first      <= 1'b0;
      restart_pend  <= 1'b0;
      data_out      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (restart) begin
            flash_address <= restart_addr;
            is_first      <= 1'b0;
          end
        end
        ISSUE: begin
          if (restart) restart_pend <= 1'b1;
        end
        WAIT_VALID: begin
          if (restart)             restart_pend <= 1'b1;
          if (flash_readdatavalid) data_out     <= flash_readdata;
        end
        DONE: begin
          // A restart seen in DONE itself is folded straight into this commit.
          restart_pend <= 1'b0;
          if (restart_pend || restart) begin
            flash_address <= restart_addr;
            is_first      <= 1'b0;
          end else if (!is_first) begin
            is_first <= 1'b1;
          end else begin
            is_first      <= 1'b0;
            flash_address <= step_addr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
